// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants, status encoding and position helpers for the
// 128b+8b Hamming SEC code used by ecc_encoder / ecc_decoder / ecc_check_stream.
package ecc_pkg;

  localparam int DATA_W  = 128;
  localparam int CODE_W  = 8;
  localparam int POS_MAX = 136;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'd0,
    ST_CORR   = 2'd1,
    ST_UNCORR = 2'd2
  } ecc_status_e;

  // True for Hamming positions that hold a check bit.
  function automatic bit is_pow2(input int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Hamming position (1..136) of data bit idx: the idx-th non-power-of-two position.
  function automatic int pos_of(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= POS_MAX; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Inverse of pos_of; returns 0 for positions that carry no data bit.
  function automatic int data_idx_of(input int pos);
    int cnt;
    int idx;
    cnt = 0;
    idx = 0;
    for (int p = 1; p <= POS_MAX; p++) begin
      if (!is_pow2(p)) begin
        if (p == pos) idx = cnt;
        cnt++;
      end
    end
    return idx;
  endfunction

  // Data bits that participate in check bit k (position has bit k set).
  function automatic logic [DATA_W-1:0] code_mask(input int k);
    logic [DATA_W-1:0] m;
    int p;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      p    = pos_of(i);
      m[i] = p[k];
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational syndrome of a received 128b data + 8b check word.
// Each syndrome bit is the received check bit XOR the parity of its data group.
module ecc_syndrome
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] syndrome
);

  genvar gi;
  generate
    for (gi = 0; gi < CODE_W; gi++) begin : g_syn
      localparam logic [DATA_W-1:0] MASK = code_mask(gi);
      assign syndrome[gi] = code[gi] ^ (^(data & MASK));
    end
  endgenerate

endmodule

// File: rtl/ecc_check_stream.sv
// ecc_check_stream: two-stage streaming SEC checker with valid/ready on both sides.
// S1 holds data/tag plus syndrome, S2 holds corrected data/tag/status.
// Saturating corrected/uncorrectable counters for CSR readout.
// Optional macro ECC_ERR_LOG_EN adds a log of tag/syndrome of the latest
// non-clean word; an uncorrectable entry is sticky until cnt_clr.
module ecc_check_stream
  import ecc_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic [7:0]        in_code,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        out_status,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr,
  output logic [TAG_W-1:0]  log_tag,
  output logic [7:0]        log_syn
);

  genvar gi;

  logic              s1_full_reg;
  logic [DATA_W-1:0] s1_data_reg;
  logic [TAG_W-1:0]  s1_tag_reg;
  logic [CODE_W-1:0] s1_syn_reg;

  logic              s2_full_reg;
  logic [DATA_W-1:0] s2_data_reg;
  logic [TAG_W-1:0]  s2_tag_reg;
  ecc_status_e       s2_status_reg;

  logic [CNT_W-1:0]  cnt_corr_reg;
  logic [CNT_W-1:0]  cnt_uncorr_reg;

  logic [CODE_W-1:0] syn_next;
  logic [DATA_W-1:0] flip_next;
  ecc_status_e       status_next;

  logic in_fire;
  logic s2_load;
  logic out_fire;

  // Each stage advances when the next one is empty or draining this cycle.
  assign s2_load  = s1_full_reg && (!s2_full_reg || out_ready);
  assign out_fire = s2_full_reg && out_ready;
  assign in_ready = !s1_full_reg || !s2_full_reg || out_ready;
  assign in_fire  = in_valid && in_ready;

  ecc_syndrome u_syndrome (
    .data     (in_data),
    .code     (in_code),
    .syndrome (syn_next)
  );

  // One comparator per data bit: only a syndrome equal to that bit's position flips it,
  // so check-bit errors (powers of two) and out-of-range syndromes flip nothing.
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_flip
      localparam logic [CODE_W-1:0] POS = CODE_W'(pos_of(gi));
      assign flip_next[gi] = (s1_syn_reg == POS);
    end
  endgenerate

  // Classify the S1 syndrome.
  always_comb begin
    status_next = ST_CORR;
    if (s1_syn_reg == '0) begin
      status_next = ST_CLEAN;
    end else if (s1_syn_reg > CODE_W'(POS_MAX)) begin
      status_next = ST_UNCORR;
    end
  end

  // S1: capture the accepted word and its syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full_reg <= 1'b0;
      s1_data_reg <= '0;
      s1_tag_reg  <= '0;
      s1_syn_reg  <= '0;
    end else begin
      if (in_fire) begin
        s1_full_reg <= 1'b1;
        s1_data_reg <= in_data;
        s1_tag_reg  <= in_tag;
        s1_syn_reg  <= syn_next;
      end else if (s2_load) begin
        s1_full_reg <= 1'b0;
      end
    end
  end

  // S2: corrected word held stable until the downstream accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_full_reg   <= 1'b0;
      s2_data_reg   <= '0;
      s2_tag_reg    <= '0;
      s2_status_reg <= ST_CLEAN;
    end else begin
      if (s2_load) begin
        s2_full_reg   <= 1'b1;
        s2_data_reg   <= s1_data_reg ^ flip_next;
        s2_tag_reg    <= s1_tag_reg;
        s2_status_reg <= status_next;
      end else if (out_fire) begin
        s2_full_reg <= 1'b0;
      end
    end
  end

  // Saturating error counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_reg   <= '0;
      cnt_uncorr_reg <= '0;
    end else if (cnt_clr) begin
      cnt_corr_reg   <= '0;
      cnt_uncorr_reg <= '0;
    end else if (s2_load) begin
      if (status_next == ST_CORR && cnt_corr_reg != '1) begin
        cnt_corr_reg <= cnt_corr_reg + 1'b1;
      end
      if (status_next == ST_UNCORR && cnt_uncorr_reg != '1) begin
        cnt_uncorr_reg <= cnt_uncorr_reg + 1'b1;
      end
    end
  end

`ifdef ECC_ERR_LOG_EN
  logic [TAG_W-1:0]  log_tag_reg;
  logic [CODE_W-1:0] log_syn_reg;
  logic              log_lock_reg;

  // Record the latest non-clean word; once an uncorrectable word is logged, later
  // corrected words leave it in place until the counters are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_tag_reg  <= '0;
      log_syn_reg  <= '0;
      log_lock_reg <= 1'b0;
    end else begin
      if (s2_load && (status_next == ST_UNCORR ||
                      (status_next == ST_CORR && (!log_lock_reg || cnt_clr)))) begin
        log_tag_reg <= s1_tag_reg;
        log_syn_reg <= s1_syn_reg;
      end
      if (s2_load && status_next == ST_UNCORR) begin
        log_lock_reg <= 1'b1;
      end else if (cnt_clr) begin
        log_lock_reg <= 1'b0;
      end
    end
  end

  assign log_tag = log_tag_reg;
  assign log_syn = log_syn_reg;
`else
  assign log_tag = '0;
  assign log_syn = '0;
`endif

  assign out_valid  = s2_full_reg;
  assign out_data   = s2_data_reg;
  assign out_tag    = s2_tag_reg;
  assign out_status = s2_status_reg;
  assign cnt_corr   = cnt_corr_reg;
  assign cnt_uncorr = cnt_uncorr_reg;

endmodule

// File: tb/tb_ecc_check_stream.sv
// tb_ecc_check_stream: directed self-checking bench for ecc_check_stream (CNT_W=4).
// Honours ECC_ERR_LOG_EN when computing expected log outputs.
module tb_ecc_check_stream;

  localparam int TAG_W = 8;
  localparam int CNT_W = 4;

`ifdef ECC_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D1 = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1357_9BDF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [127:0]      in_data = '0;
  logic [7:0]        in_code = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [127:0]      out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        out_status;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  cnt_corr;
  logic [CNT_W-1:0]  cnt_uncorr;
  logic [TAG_W-1:0]  log_tag;
  logic [7:0]        log_syn;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ecc_check_stream #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_code    (in_code),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_status (out_status),
    .cnt_clr    (cnt_clr),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr),
    .log_tag    (log_tag),
    .log_syn    (log_syn)
  );

  // Encoder model: check word is the XOR of the Hamming positions of all set data bits.
  function automatic logic [7:0] model_code(input logic [127:0] d);
    logic [7:0] c;
    int pos;
    c = 8'h00;
    pos = 1;
    for (int i = 0; i < 128; i++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[i]) c ^= pos[7:0];
      pos++;
    end
    return c;
  endfunction

  function automatic logic [127:0] bit_mask(input int idx);
    logic [127:0] one;
    one = 128'd1;
    return one << idx;
  endfunction

  task automatic pulse_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  // Send one word into an otherwise idle pipe with out_ready high; report the output
  // word and how many rising edges passed from acceptance until it was visible.
  task automatic xfer(input logic [127:0] d, input logic [7:0] c, input logic [7:0] t,
                      output logic [127:0] od, output logic [7:0] ot,
                      output logic [1:0] ost, output int lat);
    int guard;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_code   = c;
    in_tag    = t;
    out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
    od  = out_data;
    ot  = out_tag;
    ost = out_status;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    if (out_status !== 2'd0) begin failures++; $display("FAIL reset_out_status: got %0d expected 0", out_status); end
    if (cnt_corr !== '0) begin failures++; $display("FAIL reset_cnt_corr: got %0d expected 0", cnt_corr); end
    if (cnt_uncorr !== '0) begin failures++; $display("FAIL reset_cnt_uncorr: got %0d expected 0", cnt_uncorr); end
    if (log_tag !== '0) begin failures++; $display("FAIL reset_log_tag: got %h expected 0", log_tag); end
    if (log_syn !== '0) begin failures++; $display("FAIL reset_log_syn: got %h expected 0", log_syn); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
    $display("test_reset done");
  endtask

  task automatic test_clean();
    logic [127:0] vec [2];
    logic [127:0] od;
    logic [7:0] ot;
    logic [1:0] ost;
    int lat;
    vec[0] = D0;
    vec[1] = '1;
    pulse_clr();
    for (int k = 0; k < 2; k++) begin
      xfer(vec[k], model_code(vec[k]), 8'h10 + 8'(k), od, ot, ost, lat);
      $display("clean word %0d: data=%h tag=%h status=%0d latency=%0d", k, od, ot, ost, lat);
      checks += 6;
      if (od !== vec[k]) begin failures++; $display("FAIL clean_data: got %h expected %h", od, vec[k]); end
      if (ot !== 8'h10 + 8'(k)) begin failures++; $display("FAIL clean_tag: got %h expected %h", ot, 8'h10 + 8'(k)); end
      if (ost !== 2'd0) begin failures++; $display("FAIL clean_status: got %0d expected 0", ost); end
      if (lat !== 2) begin failures++; $display("FAIL clean_latency: got %0d expected 2", lat); end
      if (cnt_corr !== '0) begin failures++; $display("FAIL clean_cnt_corr: got %0d expected 0", cnt_corr); end
      if (cnt_uncorr !== '0) begin failures++; $display("FAIL clean_cnt_uncorr: got %0d expected 0", cnt_uncorr); end
    end
  endtask

  task automatic test_single_err();
    int flip_idx [2] = '{0, 127};
    logic [7:0] exp_syn [2] = '{8'd3, 8'd136};
    logic [127:0] od;
    logic [7:0] ot;
    logic [1:0] ost;
    logic [7:0] tag;
    int lat;
    pulse_clr();
    for (int k = 0; k < 2; k++) begin
      tag = 8'h20 + 8'(k);
      xfer(D1 ^ bit_mask(flip_idx[k]), model_code(D1), tag, od, ot, ost, lat);
      $display("single err bit %0d: data=%h status=%0d cnt_corr=%0d log_syn=%0d", flip_idx[k], od, ost, cnt_corr, log_syn);
      checks += 6;
      if (od !== D1) begin failures++; $display("FAIL single_data: got %h expected %h", od, D1); end
      if (ost !== 2'd1) begin failures++; $display("FAIL single_status: got %0d expected 1", ost); end
      if (lat !== 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", lat); end
      if (cnt_corr !== CNT_W'(k + 1)) begin failures++; $display("FAIL single_cnt_corr: got %0d expected %0d", cnt_corr, k + 1); end
      if (log_tag !== (LOG_EN ? tag : 8'h00)) begin failures++; $display("FAIL single_log_tag: got %h expected %h", log_tag, LOG_EN ? tag : 8'h00); end
      if (log_syn !== (LOG_EN ? exp_syn[k] : 8'h00)) begin failures++; $display("FAIL single_log_syn: got %0d expected %0d", log_syn, LOG_EN ? exp_syn[k] : 8'h00); end
    end
  endtask

  task automatic test_check_bit_err();
    logic [127:0] od;
    logic [7:0] ot;
    logic [1:0] ost;
    int lat;
    // data 0 encodes to check word 0, so flipping code[7] gives syndrome 128
    xfer('0, 8'h80, 8'h30, od, ot, ost, lat);
    $display("check-bit err: data=%h status=%0d", od, ost);
    checks += 3;
    if (od !== '0) begin failures++; $display("FAIL chkbit_data: got %h expected 0", od); end
    if (ost !== 2'd1) begin failures++; $display("FAIL chkbit_status: got %0d expected 1", ost); end
    if (log_syn !== (LOG_EN ? 8'd128 : 8'd0)) begin failures++; $display("FAIL chkbit_log_syn: got %0d expected %0d", log_syn, LOG_EN ? 8'd128 : 8'd0); end
  endtask

  task automatic test_double_err();
    logic [127:0] rx [3];
    logic [127:0] exp_d [3];
    logic [1:0] exp_st [3] = '{2'd1, 2'd2, 2'd1};
    logic [127:0] od;
    logic [7:0] ot;
    logic [1:0] ost;
    int lat;
    // bits 0,1 -> s=6 -> data[2] miscorrected
    rx[0] = D0 ^ bit_mask(0) ^ bit_mask(1);
    exp_d[0] = D0 ^ 128'h7;
    // bits 0,127 -> s=3^136=139 -> uncorrectable, passed unchanged
    rx[1] = D0 ^ bit_mask(0) ^ bit_mask(127);
    exp_d[1] = rx[1];
    // bits 126,127 -> s=135^136=15 -> data[10] miscorrected
    rx[2] = D0 ^ bit_mask(126) ^ bit_mask(127);
    exp_d[2] = rx[2] ^ bit_mask(10);
    pulse_clr();
    for (int k = 0; k < 3; k++) begin
      xfer(rx[k], model_code(D0), 8'h50 + 8'(k), od, ot, ost, lat);
      $display("double err %0d: data=%h status=%0d", k, od, ost);
      checks += 2;
      if (od !== exp_d[k]) begin failures++; $display("FAIL double_data_%0d: got %h expected %h", k, od, exp_d[k]); end
      if (ost !== exp_st[k]) begin failures++; $display("FAIL double_status_%0d: got %0d expected %0d", k, ost, exp_st[k]); end
    end
    checks += 4;
    if (cnt_corr !== CNT_W'(2)) begin failures++; $display("FAIL double_cnt_corr: got %0d expected 2", cnt_corr); end
    if (cnt_uncorr !== CNT_W'(1)) begin failures++; $display("FAIL double_cnt_uncorr: got %0d expected 1", cnt_uncorr); end
    if (log_tag !== (LOG_EN ? 8'h51 : 8'h00)) begin failures++; $display("FAIL double_log_tag: got %h expected %h", log_tag, LOG_EN ? 8'h51 : 8'h00); end
    if (log_syn !== (LOG_EN ? 8'd139 : 8'd0)) begin failures++; $display("FAIL double_log_syn: got %0d expected %0d", log_syn, LOG_EN ? 8'd139 : 8'd0); end
  endtask

  task automatic test_backpressure();
    logic [127:0] words [8];
    int sent, rcvd, cyc;
    logic saw_stall, held;
    logic [127:0] held_data;
    logic [7:0] held_tag;
    for (int k = 0; k < 8; k++) words[k] = {4{32'hC0DE_0000 + 32'(k)}};
    sent = 0; rcvd = 0; cyc = 0;
    saw_stall = 1'b0; held = 1'b0; held_data = '0; held_tag = '0;
    pulse_clr();
    while (rcvd < 8 && cyc < 80) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_data  = words[sent] ^ ((sent % 2 == 1) ? bit_mask(sent * 7) : '0);
        in_code  = model_code(words[sent]);
        in_tag   = 8'h40 + 8'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        checks++;
        if (!out_valid || out_data !== held_data || out_tag !== held_tag) begin
          failures++;
          $display("FAIL bp_hold_stable: got valid=%b tag=%h expected valid=1 tag=%h", out_valid, out_tag, held_tag);
        end
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        $display("bp word %0d: tag=%h status=%0d data=%h", rcvd, out_tag, out_status, out_data);
        checks += 3;
        if (out_data !== words[rcvd]) begin failures++; $display("FAIL bp_data_%0d: got %h expected %h", rcvd, out_data, words[rcvd]); end
        if (out_tag !== 8'h40 + 8'(rcvd)) begin failures++; $display("FAIL bp_tag_%0d: got %h expected %h", rcvd, out_tag, 8'h40 + 8'(rcvd)); end
        if (out_status !== ((rcvd % 2 == 1) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL bp_status_%0d: got %0d expected %0d", rcvd, out_status, rcvd % 2); end
        rcvd++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_tag  = out_tag;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks += 4;
    if (rcvd !== 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", rcvd); end
    if (saw_stall !== 1'b1) begin failures++; $display("FAIL bp_in_ready_drop: got %b expected 1", saw_stall); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid); end
    if (cnt_corr !== CNT_W'(4)) begin failures++; $display("FAIL bp_cnt_corr: got %0d expected 4", cnt_corr); end
  endtask

  task automatic test_saturation();
    pulse_clr();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = D0 ^ bit_mask(k);
      in_code   = model_code(D0);
      in_tag    = 8'h60 + 8'(k);
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("saturation: cnt_corr=%0d cnt_uncorr=%0d", cnt_corr, cnt_uncorr);
    checks += 2;
    if (cnt_corr !== 4'd15) begin failures++; $display("FAIL sat_cnt_corr: got %0d expected 15", cnt_corr); end
    if (cnt_uncorr !== 4'd0) begin failures++; $display("FAIL sat_cnt_uncorr: got %0d expected 0", cnt_uncorr); end
    // corrected word reaches S2 on the same edge that sees cnt_clr
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = D0 ^ bit_mask(3);
    in_code  = model_code(D0);
    in_tag   = 8'h7F;
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    $display("clear vs increment: cnt_corr=%0d out_status=%0d", cnt_corr, out_status);
    checks += 2;
    if (cnt_corr !== 4'd0) begin failures++; $display("FAIL clr_wins: got %0d expected 0", cnt_corr); end
    if (out_status !== 2'd1 || out_valid !== 1'b1) begin failures++; $display("FAIL clr_word_status: got valid=%b status=%0d expected valid=1 status=1", out_valid, out_status); end
  endtask

  task automatic test_midstream_reset();
    logic seen;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = D0 ^ bit_mask(0) ^ bit_mask(127);
    in_code   = model_code(D0);
    in_tag    = 8'hA0;
    @(negedge clk);
    in_data = D1;
    in_code = model_code(D1);
    in_tag  = 8'hA1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
    if (cnt_uncorr !== 4'd1) begin failures++; $display("FAIL mid_pre_cnt_uncorr: got %0d expected 1", cnt_uncorr); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL mid_rst_data: got %h expected 0", out_data); end
    if (cnt_uncorr !== 4'd0) begin failures++; $display("FAIL mid_rst_cnt_uncorr: got %0d expected 0", cnt_uncorr); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    $display("mid-stream reset: out_valid seen after release=%b in_ready=%b", seen, in_ready);
    checks += 2;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_partial: got %b expected 0", seen); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_check_bit_err();
    test_double_err();
    test_backpressure();
    test_saturation();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
